// File: rtl/mfp_sword_seg_shifter.sv
// Serial driver for the SWORD board's 74HC595 7-segment chain: snapshots the hex value,
// blank mask and decimal points, shifts 64 active-low segment bits out, then latches.
module mfp_sword_seg_shifter #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned GAP     = 16
) (
  input  logic        HCLK,
  input  logic        SI_Reset,
  input  logic [31:0] IO_7SEG,
  input  logic [7:0]  SEG_BLANK,
  input  logic [7:0]  SEG_DP,
  output logic        SEG_CLK,
  output logic        SEG_DAT,
  output logic        SEG_LAT,
  output logic        SEG_BUSY,
  output logic        FRAME_DONE
);

  localparam logic [7:0]  DivLast = 8'(CLK_DIV - 1);
  // Unreachable when GAP is 0: LATCH bypasses the GAP state entirely.
  localparam logic [15:0] GapLast = 16'(GAP - 1);

  typedef enum logic [1:0] {StLoad, StShift, StLatch, StGap} state_e;

  state_e      state_q;
  logic [63:0] shift_q;
  logic [7:0]  div_q;
  logic        phase_q;
  logic [5:0]  bit_q;
  logic [15:0] gap_q;
  logic [63:0] frame_bits;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Digit 7 lands in [63:56] so that shifting MSB-first sends it first.
  always_comb begin
    frame_bits = '1;
    for (int i = 0; i < 8; i++) begin
      if (!SEG_BLANK[i]) begin
        frame_bits[8*i +: 8] = {~SEG_DP[i], seg7(IO_7SEG[4*i +: 4])};
      end
    end
  end

  // All outputs are registered from the current state, so they trail the state by one cycle.
  always_ff @(posedge HCLK) begin
    if (SI_Reset) begin
      state_q    <= StLoad;
      shift_q    <= '0;
      div_q      <= '0;
      phase_q    <= 1'b0;
      bit_q      <= '0;
      gap_q      <= '0;
      SEG_CLK    <= 1'b0;
      SEG_DAT    <= 1'b1;
      SEG_LAT    <= 1'b0;
      SEG_BUSY   <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      SEG_CLK    <= 1'b0;
      SEG_DAT    <= 1'b1;
      SEG_LAT    <= 1'b0;
      SEG_BUSY   <= 1'b0;
      FRAME_DONE <= 1'b0;
      case (state_q)
        StLoad: begin
          SEG_BUSY <= 1'b1;
          shift_q  <= frame_bits;
          div_q    <= '0;
          phase_q  <= 1'b0;
          bit_q    <= 6'd63;
          state_q  <= StShift;
        end
        StShift: begin
          SEG_BUSY <= 1'b1;
          SEG_CLK  <= phase_q;
          SEG_DAT  <= shift_q[63];
          if (div_q == DivLast) begin
            div_q <= '0;
            if (!phase_q) begin
              phase_q <= 1'b1;
            end else begin
              phase_q <= 1'b0;
              shift_q <= {shift_q[62:0], 1'b1};
              if (bit_q == 6'd0) begin
                state_q <= StLatch;
              end else begin
                bit_q <= bit_q - 6'd1;
              end
            end
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        StLatch: begin
          SEG_BUSY <= 1'b1;
          SEG_LAT  <= 1'b1;
          if (div_q == DivLast) begin
            FRAME_DONE <= 1'b1;
            div_q      <= '0;
            gap_q      <= '0;
            state_q    <= (GAP == 0) ? StLoad : StGap;
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        StGap: begin
          if (gap_q == GapLast) begin
            gap_q   <= '0;
            state_q <= StLoad;
          end else begin
            gap_q <= gap_q + 16'd1;
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

endmodule

// File: tb/tb_mfp_sword_seg_shifter.sv
// Bench for mfp_sword_seg_shifter: deserializes each frame from the pins and compares it with
// a digit-by-digit model, plus frame timing, latch and reset behaviour.
module tb_mfp_sword_seg_shifter;

  logic        HCLK = 1'b0;
  logic        SI_Reset;
  logic [31:0] io;
  logic [7:0]  blank;
  logic [7:0]  dp;
  logic        sel;

  logic d_clk, d_dat, d_lat, d_busy, d_done;
  logic f_clk, f_dat, f_lat, f_busy, f_done;
  logic m_clk, m_dat, m_lat, m_busy, m_done;

  int checks   = 0;
  int failures = 0;

  always #5 HCLK = ~HCLK;

  mfp_sword_seg_shifter u_dut (
    .HCLK      (HCLK),
    .SI_Reset  (SI_Reset),
    .IO_7SEG   (io),
    .SEG_BLANK (blank),
    .SEG_DP    (dp),
    .SEG_CLK   (d_clk),
    .SEG_DAT   (d_dat),
    .SEG_LAT   (d_lat),
    .SEG_BUSY  (d_busy),
    .FRAME_DONE(d_done)
  );

  mfp_sword_seg_shifter #(
    .CLK_DIV(1),
    .GAP    (0)
  ) u_fast (
    .HCLK      (HCLK),
    .SI_Reset  (SI_Reset),
    .IO_7SEG   (io),
    .SEG_BLANK (blank),
    .SEG_DP    (dp),
    .SEG_CLK   (f_clk),
    .SEG_DAT   (f_dat),
    .SEG_LAT   (f_lat),
    .SEG_BUSY  (f_busy),
    .FRAME_DONE(f_done)
  );

  always_comb begin
    m_clk  = sel ? f_clk  : d_clk;
    m_dat  = sel ? f_dat  : d_dat;
    m_lat  = sel ? f_lat  : d_lat;
    m_busy = sel ? f_busy : d_busy;
    m_done = sel ? f_done : d_done;
  end

  // Expected 64-bit stream: one byte per digit, digit 7 first.
  function automatic logic [63:0] model(input logic [31:0] v, input logic [7:0] bl,
                                        input logic [7:0] p);
    logic [7:0]  hex [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [63:0] r = '0;
    logic [7:0]  b;
    for (int d = 7; d >= 0; d--) begin
      if (bl[d]) b = 8'hFF;
      else b = p[d] ? (hex[v[4*d +: 4]] & 8'h7F) : (hex[v[4*d +: 4]] | 8'h80);
      r = {r[55:0], b};
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs until FRAME_DONE (bounded), capturing SEG_DAT on each SEG_CLK rise.
  task automatic run_frame(input int first, input int chg_at, input logic [31:0] chg_val,
                           output logic [63:0] bits, output int n, output int rises,
                           output int lat_cyc, output int busy_cyc, output int overlap);
    logic prev;
    prev = m_clk;
    bits = '0;
    n = -1;
    rises = 0;
    lat_cyc = 0;
    busy_cyc = 0;
    overlap = 0;
    for (int i = first; i <= first + 2000; i++) begin
      @(negedge HCLK);
      if (i == chg_at) io = chg_val;
      if (m_clk && !prev) begin
        bits = {bits[62:0], m_dat};
        rises++;
      end
      prev = m_clk;
      if (m_lat) lat_cyc++;
      if (m_busy) busy_cyc++;
      if (m_lat && m_clk) overlap++;
      if (m_done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic check_frame(input string tag, input int first, input int chg_at,
                             input logic [31:0] chg_val, input logic [63:0] exp_bits,
                             input int exp_n, input int exp_busy, input int exp_lat);
    logic [63:0] bits;
    int n, rises, lat_cyc, busy_cyc, overlap;
    run_frame(first, chg_at, chg_val, bits, n, rises, lat_cyc, busy_cyc, overlap);
    chk({tag, "_bits"}, bits, exp_bits);
    chk_i({tag, "_done_cycle"}, n, exp_n);
    chk_i({tag, "_rises"}, rises, 64);
    chk_i({tag, "_lat_cycles"}, lat_cyc, exp_lat);
    chk_i({tag, "_busy_cycles"}, busy_cyc, exp_busy);
    chk_i({tag, "_clk_lat_overlap"}, overlap, 0);
  endtask

  initial begin
    logic [63:0] bits;
    logic        prev;
    int n, rises, lat_cyc, busy_cyc, overlap;

    sel      = 1'b0;
    SI_Reset = 1'b1;
    io       = 32'h0123_4567;
    blank    = 8'h00;
    dp       = 8'h00;
    repeat (5) @(negedge HCLK);
    chk("rst_clk", 64'(d_clk), 64'(0));
    chk("rst_dat", 64'(d_dat), 64'(1));
    chk("rst_lat", 64'(d_lat), 64'(0));
    chk("rst_busy", 64'(d_busy), 64'(0));
    chk("rst_done", 64'(d_done), 64'(0));
    chk("rst_fast_busy", 64'(f_busy), 64'(0));

    // This cycle is the first LOAD; BUSY follows one cycle later.
    SI_Reset = 1'b0;
    chk("load_busy_low", 64'(d_busy), 64'(0));
    @(negedge HCLK);
    chk("busy_after_load", 64'(d_busy), 64'(1));
    check_frame("f1_0123", 2, -1, '0, 64'hC0F9_A4B0_9992_82F8, 517, 516, 4);

    io = 32'h89AB_CDEF; blank = 8'h0F; dp = 8'h80;
    check_frame("f2_blank_dp", 1, -1, '0, 64'h0090_8883_FFFF_FFFF, 533, 517, 4);

    io = 32'h0; blank = 8'h00; dp = 8'h00;
    check_frame("f3_change_mid", 1, 200, 32'hFFFF_FFFF, {8{8'hC0}}, 533, 517, 4);
    check_frame("f4_after_change", 1, -1, '0, {8{8'h8E}}, 533, 517, 4);

    for (int k = 0; k < 4; k++) begin
      io    = $urandom;
      blank = 8'($urandom);
      dp    = 8'($urandom);
      check_frame($sformatf("rand%0d", k), 1, -1, '0, model(io, blank, dp), 533, 517, 4);
    end

    // Abort mid-shift at bit 30 (34th rising edge).
    prev = m_clk;
    rises = 0;
    lat_cyc = 0;
    for (int i = 0; i < 2000 && rises < 34; i++) begin
      @(negedge HCLK);
      if (m_clk && !prev) rises++;
      prev = m_clk;
      if (m_lat) lat_cyc++;
    end
    chk_i("abort_reached_bit30", rises, 34);
    SI_Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      if (m_lat) lat_cyc++;
    end
    chk_i("abort_no_latch", lat_cyc, 0);
    chk("abort_busy", 64'(d_busy), 64'(0));
    chk("abort_clk", 64'(d_clk), 64'(0));
    chk("abort_dat", 64'(d_dat), 64'(1));
    io = 32'hDEAD_BEEF; blank = 8'h24; dp = 8'h5A;
    SI_Reset = 1'b0;
    check_frame("after_abort", 1, -1, '0, model(io, blank, dp), 517, 517, 4);

    // CLK_DIV=1, GAP=0 instance: first call only aligns to a frame boundary.
    sel = 1'b1;
    io = $urandom; blank = 8'($urandom); dp = 8'($urandom);
    run_frame(1, -1, '0, bits, n, rises, lat_cyc, busy_cyc, overlap);
    check_frame("fast_a", 1, -1, '0, model(io, blank, dp), 130, 130, 1);
    check_frame("fast_b", 1, -1, '0, model(io, blank, dp), 130, 130, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
